// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and helpers for the UART baud generator
package uart_pkg;

    localparam int UART_DIV_W       = 16;
    localparam int UART_OVS         = 16;
    localparam int UART_DEFAULT_DIV = 326;
    localparam int UART_PHASE_W     = $clog2(UART_OVS);

    // Phase index whose advance lands on the bit centre (OVS/2-1 -> OVS/2)
    function automatic int uart_mid_phase(input int ovs);
        return ovs / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_phase_cnt.sv
// rtl/uart_phase_cnt.sv - modulo-OVS bit phase counter with wrap and mid-bit flags
module uart_phase_cnt
    import uart_pkg::*;
#(
    parameter int OVS = UART_OVS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   adv,
    input  logic                   clr,
    output logic [$clog2(OVS)-1:0] phase,
    output logic                   wrap,
    output logic                   mid
);

    localparam int PW = $clog2(OVS);
    localparam logic [PW-1:0] LAST_PHASE = PW'(OVS - 1);
    localparam logic [PW-1:0] MID_PHASE  = PW'(uart_mid_phase(OVS));
    localparam logic [PW-1:0] PH_ONE     = PW'(1);

    // Advance one step per oversample wrap; clear overrides a coincident advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (adv) begin
            phase <= (phase == LAST_PHASE) ? '0 : phase + PH_ONE;
        end
    end

    // Flags describe the transition this cycle's advance would make
    assign wrap = adv && !clr && (phase == LAST_PHASE);
    assign mid  = adv && !clr && (phase == MID_PHASE);

endmodule

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - runtime-divisor baud tick generator with TX, RX-mid and legacy clock outputs
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W       = UART_DIV_W,
    parameter int OVS         = UART_OVS,
    parameter int DEFAULT_DIV = UART_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    input  logic             rx_sync,
    output logic             tick_ovs,
    output logic             tick_tx,
    output logic             tick_rx_mid,
    output logic             clk_out,
    output logic             div_err
);

    localparam int PW = $clog2(OVS);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);
    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] prescaler;
    logic [DIV_W-1:0] active_div;
    logic [DIV_W-1:0] pending_div;
    logic             pending_valid;
    logic             ovs_wrap;
    logic             load_ok;
    logic             load_bad;
    logic [PW-1:0]    tx_phase;
    logic [PW-1:0]    rx_phase;
    logic             tx_wrap;
    logic             tx_mid;
    logic             rx_wrap;
    logic             rx_mid;
    logic             unused_ok;

    // active_div is never below 2, so the minus-one compare cannot underflow
    assign ovs_wrap = en && (prescaler == active_div - DIV_ONE);
    assign load_ok  = div_load && (div_in >= DIV_MIN);
    assign load_bad = div_load && (div_in < DIV_MIN);

    // Oversample prescaler: counts only while enabled, wraps at active_div-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (en) begin
            prescaler <= ovs_wrap ? '0 : prescaler + DIV_ONE;
        end
    end

    // Divisor staging: new values wait for a wrap so no period is ever truncated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_div    <= DIV_RST;
            pending_div   <= '0;
            pending_valid <= 1'b0;
        end else if (ovs_wrap) begin
            if (load_ok) begin
                active_div <= div_in;
            end else if (pending_valid) begin
                active_div <= pending_div;
            end
            pending_valid <= 1'b0;
        end else if (load_ok) begin
            pending_div   <= div_in;
            pending_valid <= 1'b1;
        end
    end

    uart_phase_cnt #(.OVS(OVS)) u_tx_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (ovs_wrap),
        .clr   (1'b0),
        .phase (tx_phase),
        .wrap  (tx_wrap),
        .mid   (tx_mid)
    );

    uart_phase_cnt #(.OVS(OVS)) u_rx_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (ovs_wrap),
        .clr   (rx_sync),
        .phase (rx_phase),
        .wrap  (rx_wrap),
        .mid   (rx_mid)
    );

    // Only the TX wrap and RX centre flags drive outputs
    assign unused_ok = ^{tx_phase, rx_phase, tx_mid, rx_wrap};

    // Registered strobes and legacy square wave, all aligned to the wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_ovs    <= 1'b0;
            tick_tx     <= 1'b0;
            tick_rx_mid <= 1'b0;
            clk_out     <= 1'b0;
            div_err     <= 1'b0;
        end else begin
            tick_ovs    <= ovs_wrap;
            tick_tx     <= tx_wrap;
            tick_rx_mid <= rx_mid;
            div_err     <= load_bad;
            if (ovs_wrap) begin
                clk_out <= ~clk_out;
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb/tb_uart_baud_gen.sv - directed self-checking bench for uart_baud_gen
module tb_uart_baud_gen;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] div_in;
    logic       div_load;
    logic       rx_sync;
    logic       tick_ovs;
    logic       tick_tx;
    logic       tick_rx_mid;
    logic       clk_out;
    logic       div_err;

    int total;
    int passed;

    uart_baud_gen #(.DIV_W(8), .OVS(4), .DEFAULT_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .div_in      (div_in),
        .div_load    (div_load),
        .rx_sync     (rx_sync),
        .tick_ovs    (tick_ovs),
        .tick_tx     (tick_tx),
        .tick_rx_mid (tick_rx_mid),
        .clk_out     (clk_out),
        .div_err     (div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until tick_ovs is seen; n = cycles taken, -1 on timeout
    task automatic wait_ovs(output int n);
        n = -1;
        for (int c = 1; c <= 100; c++) begin
            step();
            if (tick_ovs === 1'b1) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; div_in = '0; div_load = 1'b0; rx_sync = 1'b0;
        step();
        step();
        total++;
        if ({tick_ovs, tick_tx, tick_rx_mid, clk_out, div_err} !== 5'b0) begin
            $display("FAIL reset_outputs: got %b want 00000",
                     {tick_ovs, tick_tx, tick_rx_mid, clk_out, div_err});
        end else passed++;
    endtask

    task automatic test_basic();
        logic [4:0] exp_v;
        logic [4:0] got_v;
        rst_n = 1'b1;
        en    = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            exp_v = {(i % 4 == 0), (i % 16 == 0), (i % 4 == 0) && ((i / 4) % 4 == 2),
                     ((i / 4) % 2 == 1), 1'b0};
            got_v = {tick_ovs, tick_tx, tick_rx_mid, clk_out, div_err};
            total++;
            if (got_v !== exp_v) begin
                $display("FAIL basic_cycle%0d: got %b want %b (ovs,tx,rxmid,clk,err)", i, got_v, exp_v);
            end else passed++;
        end
    endtask

    task automatic test_en_low();
        int n;
        for (int i = 0; i < 6; i++) step();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if ({tick_ovs, tick_tx, tick_rx_mid, clk_out, div_err} !== 5'b00010) begin
                $display("FAIL en_low_hold%0d: got %b want 00010", i,
                         {tick_ovs, tick_tx, tick_rx_mid, clk_out, div_err});
            end else passed++;
        end
        en = 1'b1;
        wait_ovs(n);
        total++;
        if (n !== 2) $display("FAIL en_resume: got %0d cycles want 2", n);
        else passed++;
    endtask

    task automatic test_div_load();
        int n;
        step();
        div_in = 8'd6; div_load = 1'b1;
        step();
        div_load = 1'b0;
        total++;
        if (div_err !== 1'b0) $display("FAIL div_err_on_valid: got %b want 0", div_err);
        else passed++;
        wait_ovs(n);
        total++;
        if (n !== 2) $display("FAIL div_old_period_tail: got %0d cycles want 2", n);
        else passed++;
        for (int k = 0; k < 2; k++) begin
            wait_ovs(n);
            total++;
            if (n !== 6) $display("FAIL div_new_period%0d: got %0d cycles want 6", k, n);
            else passed++;
        end
        div_in = 8'd1; div_load = 1'b1;
        step();
        div_load = 1'b0;
        total++;
        if (div_err !== 1'b1) $display("FAIL div_err_pulse: got %b want 1", div_err);
        else passed++;
        step();
        total++;
        if (div_err !== 1'b0) $display("FAIL div_err_clear: got %b want 0", div_err);
        else passed++;
        wait_ovs(n);
        wait_ovs(n);
        total++;
        if (n !== 6) $display("FAIL div_after_reject: got %0d cycles want 6", n);
        else passed++;
    endtask

    task automatic test_rx_sync();
        int n;
        step();
        step();
        rx_sync = 1'b1;
        step();
        rx_sync = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            wait_ovs(n);
            total++;
            if ({n > 0, tick_rx_mid} !== {1'b1, (k == 2) || (k == 6)}) begin
                $display("FAIL rx_mid_wrap%0d: got n=%0d mid=%b want mid=%b", k, n, tick_rx_mid,
                         (k == 2) || (k == 6));
            end else passed++;
        end
        for (int k = 0; k < 3; k++) wait_ovs(n);
        for (int i = 0; i < 5; i++) step();
        rx_sync = 1'b1;
        step();
        rx_sync = 1'b0;
        total++;
        if ({tick_ovs, tick_rx_mid} !== 2'b10) begin
            $display("FAIL rx_sync_on_wrap: got ovs,mid=%b want 10", {tick_ovs, tick_rx_mid});
        end else passed++;
        for (int k = 1; k <= 2; k++) begin
            wait_ovs(n);
            total++;
            if ({n > 0, tick_rx_mid} !== {1'b1, k == 2}) begin
                $display("FAIL rx_after_wrap_sync%0d: got n=%0d mid=%b want mid=%b", k, n,
                         tick_rx_mid, k == 2);
            end else passed++;
        end
    endtask

    task automatic test_async_reset();
        int n;
        if (clk_out !== 1'b1) wait_ovs(n);
        div_in = 8'd5; div_load = 1'b1;
        step();
        div_load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({tick_ovs, tick_tx, tick_rx_mid, clk_out, div_err} !== 5'b0) begin
            $display("FAIL async_reset_outputs: got %b want 00000",
                     {tick_ovs, tick_tx, tick_rx_mid, clk_out, div_err});
        end else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ovs(n);
            total++;
            if (n !== 4) $display("FAIL post_reset_period%0d: got %0d cycles want 4", k, n);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int n;
        step();
        step();
        step();
        div_in = 8'd3; div_load = 1'b1;
        step();
        div_load = 1'b0;
        total++;
        if (tick_ovs !== 1'b1) $display("FAIL bypass_wrap_tick: got %b want 1", tick_ovs);
        else passed++;
        for (int k = 0; k < 2; k++) begin
            wait_ovs(n);
            total++;
            if (n !== 3) $display("FAIL bypass_period%0d: got %0d cycles want 3", k, n);
            else passed++;
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_basic();
        test_en_low();
        test_div_load();
        test_rx_sync();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
- Parametrised baud-rate tick generator; the next-generation replacement for the fixed-ratio UART clock divider.
- Runtime-loadable divisor producing an oversample tick, a TX bit tick and a re-alignable RX mid-bit sample tick.
- Also produces a legacy square-wave output for existing consumers.
- Sits between the system clock and the UART TX/RX engines; all outputs are single-cycle strobes in the clk domain, not derived clocks (except clk_out, kept for legacy).

Parameters:
- DIV_W, 16: width of the prescaler divisor and counter.
- OVS, 16: oversample ticks per bit; power of two, >= 4.
- DEFAULT_DIV, 326: active divisor after reset (50 MHz / (9600*16)).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  generator enable; low freezes all counters
- div_in  in  DIV_W  new divisor value
- div_load  in  1  one-cycle strobe: capture div_in
- rx_sync  in  1  one-cycle strobe: RX start-edge detected, restart RX bit phase
- tick_ovs  out  1  oversample strobe, every active-divisor clk cycles
- tick_tx  out  1  TX bit strobe, every OVS tick_ovs
- tick_rx_mid  out  1  RX sample strobe at bit centre
- clk_out  out  1  legacy square wave, toggles on every tick_ovs
- div_err  out  1  one-cycle strobe: rejected div_load

Behaviour:
- Reset (async, rst_n low): prescaler = 0, tx_phase = 0, rx_phase = 0, active_div = DEFAULT_DIV, pending_valid = 0. All outputs are 0.
- Prescaler:
  - When en = 1, it counts 0 .. active_div-1.
  - tick_ovs is registered and asserts for one cycle in the cycle after prescaler == active_div-1; prescaler wraps to 0 at that point.
- Divisor load:
  - div_load with div_in >= 2 writes pending_div and sets pending_valid.
  - div_load with div_in < 2 leaves pending state unchanged and pulses div_err the next cycle.
  - Pending is applied at the wrap (prescaler == active_div-1 with en = 1): active_div <= pending_div, pending_valid <= 0. The period in progress always completes with the old divisor.
  - div_load in the same cycle as the wrap: the new value is applied at that wrap (bypass).
  - A later div_load before application overwrites the pending value.
  - div_load is accepted regardless of en.
- TX phase:
  - Counts 0..OVS-1 on each prescaler wrap.
  - tick_tx asserts together with the tick_ovs caused by the wrap from OVS-1 to 0.
- RX phase:
  - Counts 0..OVS-1 on each prescaler wrap.
  - tick_rx_mid asserts with the tick_ovs caused by rx_phase going from OVS/2-1 to OVS/2.
- rx_sync:
  - Forces rx_phase = 0 and prescaler is not touched.
  - If rx_sync coincides with a wrap, rx_sync wins: rx_phase = 0 and that tick does not advance it.
  - First tick_rx_mid after rx_sync is therefore OVS/2 wraps later.
  - rx_sync does not affect tx_phase.
- clk_out toggles at each wrap, registered alongside tick_ovs. Period = 2*active_div clk cycles, 50% duty.
- en = 0:
  - All counters and clk_out hold.
  - tick_ovs, tick_tx and tick_rx_mid are forced 0.
  - Pending divisor is not applied.
  - Re-enabling resumes from the held counts.
- Reset mid-operation: immediate return to reset values; any pending divisor is discarded.
- Widths: the prescaler compare uses active_div-1 in DIV_W bits; underflow is impossible because active_div >= 2.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DIV_W = 16, UART_OVS = 16, UART_DEFAULT_DIV = 326.
  - A function computing OVS/2-1.
  - Phase-width constant $clog2(OVS).
- One sub-module: uart_phase_cnt (params OVS).
  - Ports: clk, rst_n, adv, clr, phase, wrap, mid.
  - Instantiated twice, for TX (clr tied 0) and RX (clr = rx_sync).
  - clr has priority over adv.

Test Plan (bench uses DIV_W=8, OVS=4, DEFAULT_DIV=4 unless stated):
- Reset then en=1 -> tick_ovs every 4 cycles, first one 4 cycles after en; tick_tx every 16 cycles; clk_out period 8 cycles, 50% duty.
- div_load div_in=6 mid-period (prescaler=1) -> current period still 4 cycles, subsequent tick_ovs spacing 6. div_load div_in=1 -> div_err pulse 1 cycle later, spacing stays 6.
- rx_sync at arbitrary cycle -> tick_rx_mid exactly 2 wraps later, then every 4 wraps. rx_sync on a wrap cycle -> rx_phase=0 and the next tick_rx_mid comes 2 further wraps later.
- en low for 10 cycles at prescaler=2 -> no ticks and clk_out frozen; after en high, next tick_ovs after 2 cycles.
- rst_n asserted asynchronously between clock edges with pending_valid=1 -> outputs 0 immediately; after release, spacing 4 (DEFAULT_DIV), pending discarded.
- div_load coincident with the wrap cycle, div_in=3 -> very next period is 3 cycles.
